// File: rtl/pipelined_ppa.sv
// Pipelined Wallace-tree partial-product adder: registered 3:2 carry-save levels
// reduce NUM_PP operands to a sum/carry pair, with an optional registered final add.
module pipelined_ppa #(
  parameter int WIDTH     = 32,
  parameter int NUM_PP    = 16,
  parameter int FINAL_ADD = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_PP*WIDTH-1:0] x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        s,
  output logic [WIDTH-1:0]        c,
  output logic [WIDTH-1:0]        sum
);

  // Operand count remaining after lvl carry-save levels.
  function automatic int ops_at(input int lvl);
    int n;
    n = NUM_PP;
    for (int i = 0; i < lvl; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int l;
    n = NUM_PP;
    l = 0;
    for (int i = 0; i < 8; i++) begin
      if (n > 2) begin
        n = 2 * (n / 3) + n % 3;
        l++;
      end
    end
    return (l < 1) ? 1 : l;
  endfunction

  localparam int L = num_levels();

  if (NUM_PP < 3 || NUM_PP > 28) begin : g_bad_num_pp
    $error("pipelined_ppa: NUM_PP must lie in 3..28");
  end

  typedef logic [NUM_PP-1:0][WIDTH-1:0] ops_t;

  // One carry-save level: full adders on consecutive triples, leftovers pass through.
  // Each adder writes its sum at 2f and its left-shifted carry at 2f+1.
  function automatic ops_t reduce(input ops_t a, input int n_in);
    ops_t r;
    int   nfa;
    r   = '0;
    nfa = n_in / 3;
    for (int f = 0; f < NUM_PP / 3; f++) begin
      if (f < nfa) begin
        r[2*f]   = a[3*f] ^ a[3*f+1] ^ a[3*f+2];
        r[2*f+1] = ((a[3*f] & a[3*f+1]) | (a[3*f] & a[3*f+2]) | (a[3*f+1] & a[3*f+2])) << 1;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (p < n_in - 3 * nfa) r[2*nfa+p] = a[3*nfa+p];
    end
    return r;
  endfunction

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // The whole pipeline freezes while a finished result waits on the consumer.
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  ops_t         xin;
  ops_t         lvl_d [L];
  ops_t         lvl_q [L];
  logic [L-1:0] vld_q;

  always_comb begin
    for (int j = 0; j < NUM_PP; j++) xin[j] = x[j*WIDTH +: WIDTH];
    lvl_d[0] = reduce(xin, NUM_PP);
    for (int k = 1; k < L; k++) lvl_d[k] = reduce(lvl_q[k-1], ops_at(k));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < L; k++) lvl_q[k] <= '0;
    end else if (!stall) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < L; k++) vld_q[k] <= vld_q[k-1];
      lvl_q <= lvl_d;
    end
  end

  if (FINAL_ADD != 0) begin : g_cpa
    logic             v_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        s_q   <= '0;
        c_q   <= '0;
        sum_q <= '0;
      end else if (!stall) begin
        v_q   <= vld_q[L-1];
        s_q   <= lvl_q[L-1][0];
        c_q   <= lvl_q[L-1][1];
        sum_q <= lvl_q[L-1][0] + lvl_q[L-1][1];
      end
    end

    assign out_valid = v_q;
    assign s         = s_q;
    assign c         = c_q;
    assign sum       = sum_q;
  end else begin : g_carry_save
    assign out_valid = vld_q[L-1];
    assign s         = lvl_q[L-1][0];
    assign c         = lvl_q[L-1][1];
    assign sum       = '0;
  end

endmodule

// File: tb/tb_pipelined_ppa.sv
// Bench for pipelined_ppa: four configurations (16/CPA, 16/carry-save, 3, 28) driven
// from directed vectors and random traffic, checked against a plain-sum reference.
module tb_pipelined_ppa;
  localparam int W    = 32;
  localparam int NMAX = 28;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic            a_iv, a_ir, a_ov, a_or;
  logic [16*W-1:0] a_x;
  logic [W-1:0]    a_s, a_c, a_sum;
  logic            b_iv, b_ir, b_ov, b_or;
  logic [W-1:0]    b_s, b_c, b_sum;
  logic            m_iv, m_ir, m_ov, m_or;
  logic [3*W-1:0]  m_x;
  logic [W-1:0]    m_s, m_c, m_sum;
  logic            n_iv, n_ir, n_ov, n_or;
  logic [28*W-1:0] n_x;
  logic [W-1:0]    n_s, n_c, n_sum;

  pipelined_ppa #(.WIDTH(W), .NUM_PP(16), .FINAL_ADD(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .x(a_x),
    .out_valid(a_ov), .out_ready(a_or), .s(a_s), .c(a_c), .sum(a_sum));
  pipelined_ppa #(.WIDTH(W), .NUM_PP(16), .FINAL_ADD(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .x(a_x),
    .out_valid(b_ov), .out_ready(b_or), .s(b_s), .c(b_c), .sum(b_sum));
  pipelined_ppa #(.WIDTH(W), .NUM_PP(3), .FINAL_ADD(1)) u_m (
    .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir), .x(m_x),
    .out_valid(m_ov), .out_ready(m_or), .s(m_s), .c(m_c), .sum(m_sum));
  pipelined_ppa #(.WIDTH(W), .NUM_PP(28), .FINAL_ADD(1)) u_n (
    .clk(clk), .rst(rst), .in_valid(n_iv), .in_ready(n_ir), .x(n_x),
    .out_valid(n_ov), .out_ready(n_or), .s(n_s), .c(n_c), .sum(n_sum));

  typedef struct packed {
    logic         kind;     // 0: PP j = base + j*step, 1: PP j = base << j
    logic [W-1:0] base;
    logic [W-1:0] step;
    logic [W-1:0] exp_sum;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [W-1:0] ref_sum(input logic [NMAX*W-1:0] v, input int n);
    logic [W-1:0] acc;
    acc = '0;
    for (int j = 0; j < n; j++) acc = acc + v[j*W +: W];
    return acc;
  endfunction

  function automatic logic [16*W-1:0] make_ops(input vec_t v);
    logic [16*W-1:0] r;
    for (int j = 0; j < 16; j++)
      r[j*W +: W] = v.kind ? (v.base << j) : (v.base + v.step * 32'(j));
    return r;
  endfunction

  // One set into both 16-operand instances; checks latency, single-cycle valid and results.
  task automatic run_single(input logic [16*W-1:0] ops, input logic [W-1:0] exp, input string tag);
    int ka, kb, na, nb;
    ka = 0; kb = 0; na = 0; nb = 0;
    a_x = ops; a_iv = 1'b1; b_iv = 1'b1; a_or = 1'b1; b_or = 1'b1;
    #1 check({tag, " in_ready"}, 32'(a_ir), 32'd1);
    @(negedge clk);
    a_iv = 1'b0; b_iv = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (a_ov) begin
        na++;
        if (ka == 0) begin
          ka = k;
          check({tag, " sum"}, a_sum, exp);
          check({tag, " s+c"}, a_s + a_c, exp);
        end
      end
      if (b_ov) begin
        nb++;
        if (kb == 0) begin
          kb = k;
          check({tag, " cs sum"}, b_sum, 32'd0);
          check({tag, " cs s+c"}, b_s + b_c, exp);
        end
      end
      @(negedge clk);
    end
    check({tag, " latency"}, ka, 32'd7);
    check({tag, " valid cycles"}, na, 32'd1);
    check({tag, " cs latency"}, kb, 32'd6);
    check({tag, " cs valid cycles"}, nb, 32'd1);
  endtask

  task automatic run_stream();
    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    e, hs, hc, hsum;
    logic [16*W-1:0] ops;
    logic            stalled_prev;
    int              sent, got, t;
    sent = 0; got = 0; t = -1; stalled_prev = 1'b0;
    hs = '0; hc = '0; hsum = '0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      if (t >= 0) t++;
      else if (a_ov) t = 0;
      a_or = (t >= 3 && t <= 5) ? 1'b0 : 1'b1;
      if (stalled_prev) begin
        check("stall hold valid", 32'(a_ov), 32'd1);
        check("stall hold s", a_s, hs);
        check("stall hold c", a_c, hc);
        check("stall hold sum", a_sum, hsum);
      end
      if (a_ov && a_or) begin
        if (exp_q.size() == 0) flag("stream unexpected output");
        else begin
          e = exp_q.pop_front();
          check("stream sum", a_sum, e);
          check("stream s+c", a_s + a_c, e);
          got++;
        end
      end
      stalled_prev = a_ov && !a_or;
      hs = a_s; hc = a_c; hsum = a_sum;
      if (sent < 10) begin
        for (int j = 0; j < 16; j++) ops[j*W +: W] = 32'(40190218 + sent + j);
        a_x = ops;
        a_iv = 1'b1;
      end else a_iv = 1'b0;
      #1 check("stream in_ready", 32'(a_ir), 32'(!(t >= 3 && t <= 5)));
      if (a_iv && a_ir) begin
        exp_q.push_back(ref_sum({{((NMAX-16)*W){1'b0}}, a_x}, 16));
        sent++;
      end
      @(negedge clk);
    end
    a_iv = 1'b0; a_or = 1'b1;
    check("stream results", got, 32'd10);
    check("stream sets sent", sent, 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (a_ov) flag("stream duplicate output");
      @(negedge clk);
    end
  endtask

  task automatic run_reset_mid();
    logic [16*W-1:0] ops;
    int              extra;
    a_or = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 16; j++) ops[j*W +: W] = $urandom();
      a_x = ops; a_iv = 1'b1;
      @(negedge clk);
    end
    a_iv = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset precondition valid", 32'(a_ov), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midreset out_valid", 32'(a_ov), 32'd0);
    check("midreset s", a_s, 32'd0);
    check("midreset c", a_c, 32'd0);
    check("midreset sum", a_sum, 32'd0);
    check("midreset in_ready", 32'(a_ir), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      if (a_ov) extra++;
      @(negedge clk);
    end
    check("midreset discarded outputs", extra, 32'd0);
    for (int j = 0; j < 16; j++) ops[j*W +: W] = 32'd1;
    run_single(ops, 32'd16, "post-reset ones");
  endtask

  task automatic run_lat_mn();
    int km, kn;
    km = 0; kn = 0;
    for (int j = 0; j < 3; j++) m_x[j*W +: W] = $urandom();
    for (int j = 0; j < 28; j++) n_x[j*W +: W] = $urandom();
    m_iv = 1'b1; n_iv = 1'b1; m_or = 1'b1; n_or = 1'b1;
    @(negedge clk);
    m_iv = 1'b0; n_iv = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (m_ov && km == 0) begin
        km = k;
        check("pp3 first sum", m_sum, ref_sum({{((NMAX-3)*W){1'b0}}, m_x}, 3));
      end
      if (n_ov && kn == 0) begin
        kn = k;
        check("pp28 first sum", n_sum, ref_sum(n_x, 28));
      end
      @(negedge clk);
    end
    check("pp3 latency", km, 32'd2);
    check("pp28 latency", kn, 32'd8);
  endtask

  task automatic run_random();
    logic [W-1:0] mq[$];
    logic [W-1:0] nq[$];
    logic [W-1:0] e;
    logic         m_hold, n_hold;
    int           m_sent, n_sent, m_got, n_got;
    m_sent = 0; n_sent = 0; m_got = 0; n_got = 0;
    m_hold = 1'b0; n_hold = 1'b0;
    for (int cyc = 0; cyc < 20000 && (m_got < 1000 || n_got < 1000); cyc++) begin
      m_or = ($urandom_range(0, 3) != 0);
      n_or = ($urandom_range(0, 3) != 0);
      if (m_ov && m_or) begin
        if (mq.size() == 0) flag("pp3 unexpected output");
        else begin
          e = mq.pop_front();
          check("pp3 sum", m_sum, e);
          check("pp3 s+c", m_s + m_c, e);
          m_got++;
        end
      end
      if (n_ov && n_or) begin
        if (nq.size() == 0) flag("pp28 unexpected output");
        else begin
          e = nq.pop_front();
          check("pp28 sum", n_sum, e);
          check("pp28 s+c", n_s + n_c, e);
          n_got++;
        end
      end
      if (!m_hold) begin
        m_iv = (m_sent < 1000) && ($urandom_range(0, 3) != 0);
        for (int j = 0; j < 3; j++) m_x[j*W +: W] = $urandom();
      end
      if (!n_hold) begin
        n_iv = (n_sent < 1000) && ($urandom_range(0, 3) != 0);
        for (int j = 0; j < 28; j++) n_x[j*W +: W] = $urandom();
      end
      #1;
      if (m_iv && m_ir) begin
        mq.push_back(ref_sum({{((NMAX-3)*W){1'b0}}, m_x}, 3));
        m_sent++;
        m_hold = 1'b0;
      end else m_hold = m_iv;
      if (n_iv && n_ir) begin
        nq.push_back(ref_sum(n_x, 28));
        n_sent++;
        n_hold = 1'b0;
      end else n_hold = n_iv;
      @(negedge clk);
    end
    m_iv = 1'b0; n_iv = 1'b0;
    check("pp3 results received", m_got, 32'd1000);
    check("pp28 results received", n_got, 32'd1000);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'd40190218,   32'd1,          32'd643043608};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFF0};
    vecs[2] = '{1'b0, 32'd1,          32'd0,          32'd16};
    vecs[3] = '{1'b0, 32'd0,          32'd0,          32'd0};
    vecs[4] = '{1'b1, 32'd1,          32'd0,          32'h0000_FFFF};
    vecs[5] = '{1'b0, 32'h8000_0000,  32'd0,          32'd0};
    vecs[6] = '{1'b0, 32'd0,          32'd1,          32'd120};
    vecs[7] = '{1'b0, 32'hAAAA_AAAA,  32'd0,          32'hAAAA_AAA0};
    vecs[8] = '{1'b1, 32'h0001_0001,  32'd0,          32'hFFFF_FFFF};
    vecs[9] = '{1'b0, 32'h1234_5678,  32'h1111_1111,  32'h2345_6778};

    rst = 1'b1;
    a_iv = 1'b0; b_iv = 1'b0; m_iv = 1'b0; n_iv = 1'b0;
    a_or = 1'b1; b_or = 1'b1; m_or = 1'b1; n_or = 1'b1;
    a_x = '0; m_x = '0; n_x = '0;
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(a_ov), 32'd0);
    check("reset s", a_s, 32'd0);
    check("reset c", a_c, 32'd0);
    check("reset sum", a_sum, 32'd0);
    check("reset in_ready", 32'(a_ir), 32'd1);
    check("reset cs out_valid", 32'(b_ov), 32'd0);
    check("reset pp3 out_valid", 32'(m_ov), 32'd0);
    check("reset pp28 out_valid", 32'(n_ov), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_single(make_ops(vecs[i]), vecs[i].exp_sum, $sformatf("vec%0d", i));
    run_stream();
    run_reset_mid();
    run_lat_mn();
    run_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_ppa.md
Name: pipelined_ppa

Overview:
- Parametrised, pipelined partial-product adder: a Wallace tree of 3:2 carry-save levels, with a register after every level.
- Reduces NUM_PP operands of WIDTH bits to a sum/carry pair, plus an optional final carry-propagate add.
- Successor to the combinational 16x32 PPA; sits between the partial-product generator and the product register of the multiplier.
- Adds valid/ready flow control and stall handling.

Parameters:
- WIDTH, 32: bit width of each partial product and of all results.
- NUM_PP, 16: number of partial products; legal range 3..28; elaboration fails outside this range.
- FINAL_ADD, 1: 1 adds a registered CPA stage driving sum; 0 ties sum to 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the x bus holds a valid operand set.
- in_ready  output  1  the block accepts x this cycle.
- x  input  NUM_PP*WIDTH  partial products; PP j occupies bits [j*WIDTH +: WIDTH].
- out_valid  output  1  s, c and sum are valid.
- out_ready  input  1  the consumer accepts the result this cycle.
- s  output  WIDTH  carry-save sum vector.
- c  output  WIDTH  carry-save carry vector, already left-aligned; add it directly to s.
- sum  output  WIDTH  s+c mod 2^WIDTH when FINAL_ADD=1, else 0.

Behaviour:
- Levels L: NUM_PP 3→1, 4→2, 5-6→3, 7-9→4, 10-13→5, 14-19→6, 20-28→7.
- Level rule: each level groups operands in threes into full adders; remaining 1 or 2 operands pass through unchanged.
- Carry rule: carry is shifted left by 1; the bit shifted out of the MSB is discarded. All arithmetic is mod 2^WIDTH.
- Pipeline: one register per level, plus one for the CPA when FINAL_ADD=1. Latency LAT = L + FINAL_ADD cycles from acceptance to out_valid.
  - NUM_PP=16: LAT=7 with FINAL_ADD=1, LAT=6 with FINAL_ADD=0.
- Valid bit: each stage carries a valid bit alongside its data.
- Handshake: a transfer occurs when valid and ready are both high on a rising edge.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stall is high, every stage register (data and valid) holds.
  - in_valid is ignored while stall is high.
- Throughput: one operand set per cycle when out_ready is held high.
- Bubbles: bubbles propagate as valid=0. Data registers in invalid stages still load but are don't-care.
- Output stability: while out_valid=1 and out_ready=0, s, c and sum must stay stable.
- Invariant: whenever out_valid=1, (s+c) mod 2^WIDTH equals the sum of all NUM_PP inputs mod 2^WIDTH, and sum equals that value when FINAL_ADD=1.
- Reset:
  - All valid bits clear immediately.
  - Asserted outputs while rst is high: out_valid=0, s=0, c=0, sum=0, in_ready=1.
  - Reset mid-operation discards all in-flight sets; none emerge after release.
- After reset release: the first accepted set appears exactly LAT cycles later.
- Simultaneous events: out_ready low in the same cycle a new set is presented means the set is not accepted (in_ready=0); the producer must hold it.

Test Plan:
- Ramp inputs: NUM_PP=16, WIDTH=32, PP j = 40190218+j, single-cycle in_valid, out_ready=1 → out_valid exactly 7 cycles later for one cycle; sum=643043608; s+c=643043608.
- Overflow: all PPs = 0xFFFFFFFF → sum=0xFFFFFFF0.
- Carry-save mode: FINAL_ADD=0, same overflow stimulus → LAT=6, sum=0, s+c mod 2^32 = 0xFFFFFFF0.
- Streaming with stall: 10 back-to-back sets i=0..9, PP j = 40190218+i+j, out_ready low for cycles 3-5 after the first out_valid →
  - in_ready low exactly while stalled;
  - results emerge in order, sum_i = 643043608+16*i;
  - no set is lost or duplicated.
- Reset mid-flight: assert rst for 1 cycle while 4 sets are in the pipe → out_valid=0 immediately; no output afterwards; a new set with all PPs = 1 gives sum=16 at LAT.
- Minimum and maximum sizes: NUM_PP=3 (LAT=2) and NUM_PP=28 (LAT=8), random inputs over 1000 sets → scoreboard matches the reference sum mod 2^WIDTH.
